// File: rtl/one_four_demux_buf_pkg.sv
// Shared channel-select type and channel indices for the 1-to-4 steering demux.
package one_four_demux_buf_pkg;

  typedef logic [1:0] ch_sel_t;

  localparam int NUM_CH = 4;
  localparam int CH_A   = 0;
  localparam int CH_B   = 1;
  localparam int CH_C   = 2;
  localparam int CH_D   = 3;

endpackage

// File: rtl/one_four_demux_buf_chan_fifo.sv
// Per-channel FIFO; the head word is held in a register so it keeps its
// last value once the FIFO drains.
module one_four_demux_buf_chan_fifo
  import one_four_demux_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic             do_push, do_pop;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = head_data_q;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[tail_q] = push_data;
      tail_d        = tail_q + ONE_PTR;
    end
    if (do_pop) begin
      head_d = head_q + ONE_PTR;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
    // Look ahead at the post-update head so a push into an empty FIFO is visible next cycle.
    head_data_d = (count_d != '0) ? mem_d[head_d] : head_data_q;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      head_data_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      head_data_q <= head_data_d;
    end
  end

endmodule

// File: rtl/one_four_demux_buf.sv
// Registered 1-to-4 demux: steers one valid/ready stream into four buffered
// consumer channels so a stalled consumer only blocks beats addressed to it.
module one_four_demux_buf
  import one_four_demux_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data_a,
  output logic [WIDTH-1:0] out_data_b,
  output logic [WIDTH-1:0] out_data_c,
  output logic [WIDTH-1:0] out_data_d,
  output logic [15:0]      drop_cnt
);

  ch_sel_t           sel;
  logic [NUM_CH-1:0] push, pop, full, empty;
  logic [WIDTH-1:0]  head [NUM_CH];
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  assign sel       = ch_sel_t'(in_sel);
  // Depends only on registered occupancy, never on out_ready.
  assign in_ready  = rst_n & ~full[sel];
  assign out_valid = ~empty;
  assign pop       = out_ready & ~empty;

  always_comb begin
    push = '0;
    if (in_valid && in_ready) begin
      push[sel] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    one_four_demux_buf_chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[i]),
      .push_data (in_data),
      .full      (full[i]),
      .pop       (pop[i]),
      .empty     (empty[i]),
      .head_data (head[i])
    );
  end

  assign out_data_a = head[CH_A];
  assign out_data_b = head[CH_B];
  assign out_data_c = head[CH_C];
  assign out_data_d = head[CH_D];

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (in_valid && !in_ready && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;

endmodule
